mem_bus_master: RTL and testbench

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_master.sv | 105 ++++++++++
 tb/tb_mem_bus_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// mem_bus_master: CPU load/store bridge to a half-word-banked memory on a shared tristate bus
module mem_bus_master #(
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  inout  wire  [31:0] BUS,
  output logic        Memread,
  output logic [1:0]  Memwrite,
  output logic [11:0] Addrin
);
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;
  localparam logic [2:0] LAST = 3'(READ_LAT - 1);
  state_t state;
  logic [2:0] cnt;
  logic [1:0] size, alo;
  logic sgn, bad;
  logic [7:0] wbyte, lb;
  logic [15:0] hw;
  logic [4:0] sh;
  logic [31:0] bus_q, ld, merged;
  // The bus is only ever driven while a write strobe is up.
  assign BUS = |Memwrite ? bus_q : 32'bz;
  assign req_ready = state == IDLE && !rst;
  always_comb begin
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    sh = {alo, 3'b000};
    lb = 8'(BUS >> sh);
    hw = alo[1] ? BUS[31:16] : BUS[15:0];
    ld = size == 2'b00 ? {{24{sgn & lb[7]}}, lb} : size == 2'b01 ? {{16{sgn & hw[15]}}, hw} : BUS;
    merged = (BUS & ~(32'hFF << sh)) | ({24'h0, wbyte} << sh);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      size <= '0;
      alo <= '0;
      sgn <= 1'b0;
      wbyte <= '0;
      bus_q <= '0;
      Memread <= 1'b0;
      Memwrite <= 2'b00;
      Addrin <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      Memwrite <= 2'b00;
      case (state)
        IDLE: if (req_valid) begin
          size <= req_size;
          sgn <= req_signed;
          alo <= req_addr[1:0];
          wbyte <= req_wdata[7:0];
          cnt <= LAST;
          if (bad) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_err <= 1'b1;
          end else begin
            Addrin <= req_addr[13:2];
            Memread <= !req_we || req_size == 2'b00;
            state <= !req_we ? RD : req_size == 2'b00 ? RMW_RD : WR;
            if (req_we && req_size != 2'b00) begin
              Memwrite <= req_size == 2'b10 ? 2'b11 : {req_addr[1], !req_addr[1]};
              bus_q <= req_size == 2'b10 ? req_wdata : {2{req_wdata[15:0]}};
            end
          end
        end
        RD, RMW_RD: if (cnt == 3'd0) begin
          Memread <= 1'b0;
          state <= state == RD ? RESP : RMW_WR;
          if (state == RD) begin
            resp_valid <= 1'b1;
            resp_rdata <= ld;
          end else begin
            Memwrite <= {alo[1], !alo[1]};
            bus_q <= merged;
          end
        end else begin
          cnt <= cnt - 3'd1;
        end
        WR, RMW_WR: begin
          resp_valid <= 1'b1;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: randomized load/store traffic checked against a word-array memory model
module tb_mem_bus_master;
  localparam int L = 2;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [13:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic req_ready, resp_valid, resp_err, Memread;
  logic [31:0] resp_rdata;
  logic [1:0] Memwrite;
  logic [11:0] Addrin;
  wire [31:0] BUS;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] probe = 32'h0;
  logic mon_en = 0;
  int n_chk = 0, n_pass = 0;
  logic [31:0] last_rdata;
  logic last_err;
  logic [15:0] last_wh;
  logic [1:0] last_wmw;
  logic [11:0] last_wa;

  always #5 clk = ~clk;

  mem_bus_master #(.READ_LAT(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .BUS(BUS),
    .Memread(Memread), .Memwrite(Memwrite), .Addrin(Addrin)
  );

  // Memory side: answers reads, latches banked writes, otherwise drives a random probe
  // so that any stray DUT drive shows up as a corrupted value.
  assign BUS = Memread ? mem[Addrin[3:0]] : (|Memwrite) ? 32'bz : probe;
  always @(posedge clk) begin
    if (Memwrite[0]) mem[Addrin[3:0]][15:0] <= BUS[15:0];
    if (Memwrite[1]) mem[Addrin[3:0]][31:16] <= BUS[31:16];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("rd_wr_exclusive", 32'(Memread && Memwrite != 2'b00), 32'h0);
    if (!Memread && Memwrite == 2'b00) chk("bus_released", BUS, probe);
    probe <= $urandom;
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [13:0] a, input logic [31:0] wd);
    logic err;
    int lat, nrd, seen_rd, seen_wr, n, sh;
    logic [31:0] w, er, b;
    logic [1:0] emw;
    logic [15:0] nh;
    err = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    w = ref_mem[a[5:2]];
    sh = 8 * int'(a[1:0]);
    er = 0; emw = 0; nh = 0; nrd = 0; lat = 1;
    if (!err && !we) begin
      lat = L + 1; nrd = L;
      if (sz == 2'd0) begin
        b = (w >> sh) & 32'hFF;
        er = (sg && b[7]) ? (b | 32'hFFFFFF00) : b;
      end else if (sz == 2'd1) begin
        b = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
        er = (sg && b[15]) ? (b | 32'hFFFF0000) : b;
      end else er = w;
    end else if (!err) begin
      emw = a[1] ? 2'b10 : 2'b01;
      if (sz == 2'd2) begin
        w = wd; lat = 2; emw = 2'b11;
      end else if (sz == 2'd1) begin
        sh = a[1] ? 16 : 0;
        w = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh); lat = 2;
      end else begin
        w = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh); lat = L + 2; nrd = L;
      end
      ref_mem[a[5:2]] = w;
      nh = a[1] ? w[31:16] : w[15:0];
    end
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept", 32'(req_ready), 32'h1);
    if (!req_ready) begin req_valid = 0; return; end
    @(negedge clk);
    req_valid = 0; req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = 14'($urandom); req_wdata = $urandom;
    seen_rd = 0; seen_wr = 0;
    for (int k = 1; k <= lat; k++) begin
      if (Memread) begin seen_rd++; chk("rd_addr", 32'(Addrin), 32'(a[13:2])); end
      if (Memwrite != 2'b00) begin
        seen_wr++;
        last_wmw = Memwrite; last_wa = Addrin; last_wh = a[1] ? BUS[31:16] : BUS[15:0];
        chk("wr_enable", 32'(Memwrite), 32'(emw));
        chk("wr_addr", 32'(Addrin), 32'(a[13:2]));
        if (sz == 2'd2) chk("wr_word", BUS, wd);
        else chk("wr_half", 32'(last_wh), 32'(nh));
      end
      chk("resp_valid", 32'(resp_valid), 32'(k == lat));
      if (k == lat) begin
        last_rdata = resp_rdata; last_err = resp_err;
        chk("resp_rdata", resp_rdata, er);
        chk("resp_err", 32'(resp_err), 32'(err));
      end
      if (k < lat) @(negedge clk);
    end
    chk("rd_cycles", 32'(seen_rd), 32'(nrd));
    chk("wr_pulses", 32'(seen_wr), 32'(emw != 2'b00));
    @(negedge clk);
    chk("ready_after_resp", 32'(req_ready), 32'h1);
    chk("resp_one_cycle", 32'(resp_valid), 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_memread", 32'(Memread), 32'h0);
    chk("rst_memwrite", 32'(Memwrite), 32'h0);
    chk("rst_addrin", 32'(Addrin), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    chk("rst_bus", BUS, probe);
    rst = 0; mon_en = 1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'h1);
    for (int i = 0; i < 16; i++) do_req(1, 2'd2, 0, 14'(i * 4), $urandom);
    do_req(1, 2'd2, 0, 14'h010, 32'hDEADBEEF);
    chk("lit_word_wr_addr", 32'(last_wa), 32'h004);
    chk("lit_word_wr_en", 32'(last_wmw), 32'h3);
    do_req(0, 2'd2, 0, 14'h010, 0);
    chk("lit_word_load", last_rdata, 32'hDEADBEEF);
    do_req(1, 2'd2, 0, 14'h020, 32'h80FF7F01);
    do_req(0, 2'd0, 1, 14'h022, 0);
    chk("lit_sbyte", last_rdata, 32'hFFFFFFFF);
    do_req(0, 2'd0, 0, 14'h022, 0);
    chk("lit_ubyte", last_rdata, 32'h000000FF);
    do_req(0, 2'd1, 1, 14'h022, 0);
    chk("lit_shalf", last_rdata, 32'hFFFF80FF);
    do_req(0, 2'd1, 0, 14'h020, 0);
    chk("lit_uhalf", last_rdata, 32'h00007F01);
    do_req(1, 2'd2, 0, 14'h030, 32'h11223344);
    do_req(1, 2'd0, 0, 14'h033, 32'h000000AA);
    chk("lit_rmw_en", 32'(last_wmw), 32'h2);
    chk("lit_rmw_half", 32'(last_wh), 32'h0000AA22);
    do_req(0, 2'd2, 0, 14'h030, 0);
    chk("lit_rmw_word", last_rdata, 32'hAA223344);
    do_req(0, 2'd2, 0, 14'h002, 0);
    chk("lit_err_word", 32'(last_err), 32'h1);
    do_req(0, 2'd1, 0, 14'h001, 0);
    chk("lit_err_half", 32'(last_err), 32'h1);
    do_req(1, 2'd3, 0, 14'h004, 32'h12345678);
    chk("lit_err_size", 32'(last_err), 32'h1);
    // Reset in the middle of a byte store's read phase must drop it without writing.
    req_we = 1; req_size = 2'd0; req_signed = 0; req_addr = 14'h031; req_wdata = 32'h55; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    chk("abort_in_rmw_rd", 32'(Memread), 32'h1);
    rst = 1;
    @(negedge clk);
    chk("abort_memwrite", 32'(Memwrite), 32'h0);
    chk("abort_memread", 32'(Memread), 32'h0);
    chk("abort_resp", 32'(resp_valid), 32'h0);
    chk("abort_ready_low", 32'(req_ready), 32'h0);
    chk("abort_bus", BUS, probe);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_write", 32'(Memwrite), 32'h0);
      chk("abort_no_resp", 32'(resp_valid), 32'h0);
      chk("abort_ready", 32'(req_ready), 32'h1);
    end
    do_req(0, 2'd2, 0, 14'h030, 0);
    chk("lit_abort_word", last_rdata, 32'hAA223344);
    repeat (250) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(1'($urandom), 2'($urandom), 1'($urandom), 14'($urandom_range(0, 63)), $urandom);
    end
    for (int i = 0; i < 16; i++) do_req(0, 2'd2, 0, 14'(i * 4), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
